// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 serial byte receiver, 16x oversampling, 5-sample majority vote
module uart_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] baud_set,
  input  logic       rs232_rx,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       frame_err,
  output logic       uart_state
);

  typedef enum logic {S_IDLE, S_RECV} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_line_d;
  logic [8:0]             r_period_m1;
  logic [8:0]             r_div_cnt;
  logic [3:0]             r_sub_cnt;
  logic [3:0]             r_bit_cnt;
  logic [2:0]             r_vote;
  logic [7:0]             r_shift;
  logic [7:0]             r_data_byte;
  logic                   r_rx_done;
  logic                   r_frame_err;
  logic                   r_uart_state;

  logic                   w_line;
  logic                   w_fall;
  logic [8:0]             w_period_m1;
  logic                   w_tick;
  logic                   w_in_window;
  logic [2:0]             w_vote_sum;
  logic                   w_bit_val;
  logic                   w_mid;
  logic                   w_false_start;
  logic                   w_stop_done;

  assign w_line = r_sync[SYNC_STAGES-1];
  assign w_fall = ~w_line & r_line_d;

  always_comb begin
    case (baud_set)
      4'd1:    w_period_m1 = 9'd162;
      4'd2:    w_period_m1 = 9'd80;
      4'd3:    w_period_m1 = 9'd53;
      4'd4:    w_period_m1 = 9'd26;
      default: w_period_m1 = 9'd325;
    endcase
  end

  assign w_tick        = (r_state == S_RECV) && (r_div_cnt == r_period_m1);
  assign w_in_window   = (r_sub_cnt >= 4'd6) && (r_sub_cnt <= 4'd10);
  // The current sample is folded in so the decision at sub_cnt 10 sees all five votes
  assign w_vote_sum    = w_in_window ? (r_vote + {2'b00, w_line}) : r_vote;
  assign w_bit_val     = (w_vote_sum >= 3'd3);
  assign w_mid         = w_tick && (r_sub_cnt == 4'd10);
  assign w_false_start = w_mid && (r_bit_cnt == 4'd0) && w_bit_val;
  assign w_stop_done   = w_mid && (r_bit_cnt == 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '1;
      r_line_d <= 1'b1;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], rs232_rx};
      r_line_d <= w_line;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_fall) w_state_next = S_RECV;
      S_RECV: if (w_false_start || w_stop_done) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period_m1  <= '0;
      r_div_cnt    <= '0;
      r_sub_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_vote       <= '0;
      r_shift      <= '0;
      r_data_byte  <= '0;
      r_rx_done    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_uart_state <= 1'b0;
    end else begin
      r_rx_done    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_uart_state <= (r_state == S_RECV);
      if (r_state == S_IDLE) begin
        if (w_fall) begin
          r_period_m1 <= w_period_m1;
          r_div_cnt   <= '0;
          r_sub_cnt   <= '0;
          r_bit_cnt   <= '0;
          r_vote      <= '0;
        end
      end else if (w_tick) begin
        r_div_cnt <= '0;
        r_sub_cnt <= r_sub_cnt + 4'd1;
        if (r_sub_cnt == 4'd15) r_bit_cnt <= r_bit_cnt + 4'd1;
        r_vote <= (r_sub_cnt == 4'd0) ? 3'd0 : w_vote_sum;
        if (w_mid && (r_bit_cnt >= 4'd1) && (r_bit_cnt <= 4'd8))
          r_shift <= {w_bit_val, r_shift[7:1]};
        if (w_stop_done) begin
          r_data_byte <= r_shift;
          r_rx_done   <= 1'b1;
          r_frame_err <= ~w_bit_val;
        end
      end else begin
        r_div_cnt <= r_div_cnt + 9'd1;
      end
    end
  end

  assign data_byte  = r_data_byte;
  assign rx_done    = r_rx_done;
  assign frame_err  = r_frame_err;
  assign uart_state = r_uart_state;

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb/tb_uart_byte_rx.sv - directed self-checking bench for uart_byte_rx
module tb_uart_byte_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] baud_set = 4'd4;
  logic       rs232_rx = 1'b1;
  logic [7:0] data_byte;
  logic       rx_done;
  logic       frame_err;
  logic       uart_state;

  int n_checks = 0;
  int n_fails  = 0;

  int         done_cnt = 0;
  logic [7:0] data_log [0:15];
  logic       ferr_log [0:15];
  logic       state_after = 1'b1;
  logic       pend = 1'b0;
  logic       mid_state = 1'b0;

  uart_byte_rx #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_set   (baud_set),
    .rs232_rx   (rs232_rx),
    .data_byte  (data_byte),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .uart_state (uart_state)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (pend) begin
      state_after = uart_state;
      pend = 1'b0;
    end
    if (rx_done) begin
      if (done_cnt < 16) begin
        data_log[done_cnt] = data_byte;
        ferr_log[done_cnt] = frame_err;
      end
      done_cnt = done_cnt + 1;
      pend = 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives nbits of a {stop, data, start} frame; spike_off >= 0 inverts one cycle per bit
  task automatic send_frame(input logic [7:0] b, input int bclk, input logic stop_v,
                            input int spike_off, input int nbits);
    logic [9:0] fr;
    fr = {stop_v, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < bclk; c++) begin
        @(negedge clk);
        rs232_rx = (c == spike_off) ? ~fr[i] : fr[i];
        if (i == 5 && c == bclk / 2) mid_state = uart_state;
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rs232_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  int c0;

  initial begin
    repeat (5) @(negedge clk);
    check_eq("rst_data", {24'd0, data_byte}, 32'h00);
    check_eq("rst_done", {31'd0, rx_done}, 32'd0);
    check_eq("rst_ferr", {31'd0, frame_err}, 32'd0);
    check_eq("rst_state", {31'd0, uart_state}, 32'd0);
    rst_n = 1'b1;
    idle(20);

    // nominal, 115200
    baud_set = 4'd4;
    c0 = done_cnt;
    send_frame(8'h55, 432, 1'b1, -1, 10);
    idle(20);
    check_eq("nom_count", done_cnt - c0, 1);
    check_eq("nom_data", {24'd0, data_log[c0]}, 32'h55);
    check_eq("nom_ferr", {31'd0, ferr_log[c0]}, 32'd0);
    check_eq("nom_busy_mid", {31'd0, mid_state}, 32'd1);
    check_eq("nom_state_after", {31'd0, state_after}, 32'd0);

    // back-to-back, 38400, no idle gap
    baud_set = 4'd2;
    c0 = done_cnt;
    send_frame(8'hA5, 1296, 1'b1, -1, 10);
    send_frame(8'h3C, 1296, 1'b1, -1, 10);
    idle(20);
    check_eq("b2b_count", done_cnt - c0, 2);
    check_eq("b2b_data0", {24'd0, data_log[c0]}, 32'hA5);
    check_eq("b2b_data1", {24'd0, data_log[c0+1]}, 32'h3C);
    check_eq("b2b_ferr", {30'd0, ferr_log[c0], ferr_log[c0+1]}, 32'd0);

    // glitch, 9600
    baud_set = 4'd0;
    c0 = done_cnt;
    @(negedge clk);
    rs232_rx = 1'b0;
    repeat (100) @(negedge clk);
    rs232_rx = 1'b1;
    repeat (900) @(negedge clk);
    check_eq("glitch_busy", {31'd0, uart_state}, 32'd1);
    repeat (4000) @(negedge clk);
    check_eq("glitch_idle", {31'd0, uart_state}, 32'd0);
    check_eq("glitch_count", done_cnt - c0, 0);
    check_eq("glitch_data", {24'd0, data_byte}, 32'h3C);

    // frame error, 38400
    baud_set = 4'd2;
    c0 = done_cnt;
    send_frame(8'hF0, 1296, 1'b0, -1, 10);
    idle(1400);
    check_eq("ferr_count", done_cnt - c0, 1);
    check_eq("ferr_flag", {31'd0, ferr_log[c0]}, 32'd1);
    check_eq("ferr_data", {24'd0, data_log[c0]}, 32'hF0);

    // noise spike near sub_cnt 8 of each bit, 115200
    baud_set = 4'd4;
    c0 = done_cnt;
    send_frame(8'h81, 432, 1'b1, 240, 10);
    idle(20);
    check_eq("noise_count", done_cnt - c0, 1);
    check_eq("noise_data", {24'd0, data_log[c0]}, 32'h81);
    check_eq("noise_ferr", {31'd0, ferr_log[c0]}, 32'd0);

    // reset in bit 4, then a 57600 frame
    baud_set = 4'd3;
    send_frame(8'h3C, 864, 1'b1, -1, 4);
    rs232_rx = 1'b1;
    repeat (432) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_data", {24'd0, data_byte}, 32'h00);
    check_eq("mrst_done", {31'd0, rx_done}, 32'd0);
    check_eq("mrst_ferr", {31'd0, frame_err}, 32'd0);
    check_eq("mrst_state", {31'd0, uart_state}, 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    idle(1000);
    c0 = done_cnt;
    send_frame(8'hC3, 864, 1'b1, -1, 10);
    idle(20);
    check_eq("loop_count", done_cnt - c0, 1);
    check_eq("loop_data", {24'd0, data_log[c0]}, 32'hC3);
    check_eq("loop_ferr", {31'd0, ferr_log[c0]}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
